// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the multi-channel clock generator.
//   cnt_t      : default-width counter type (16 bits)
//   DEF_PERIOD : reset period in clk cycles (4 -> 25 MHz from 100 MHz)
//   DEF_HIGH   : reset high-time in clk cycles (2 -> 50% duty)
//   state_t    : per-channel run state
package clk_gen_pkg;
  localparam int CNT_W_DEF = 16;
  typedef logic [CNT_W_DEF-1:0] cnt_t;

  localparam cnt_t DEF_PERIOD = 16'd4;
  localparam cnt_t DEF_HIGH   = 16'd2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: counter, active and pending configuration,
// registered clk_out/tick.
// Ports:
//   clk, rst           : system clock, async active-high reset
//   en                 : run enable
//   sync               : phase-align strobe (restart counting if running)
//   cfg_period/high    : new configuration, captured on cfg_load
//   cfg_pending        : captured configuration not yet applied
//   clk_out, tick      : divided clock, period-start pulse
module clk_gen_chan #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_pending,
  output logic             clk_out,
  output logic             tick
);
  import clk_gen_pkg::*;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0] pper_q, phi_q;
  logic             pend_q, apply, wrap, restart;
  logic             clk_d, tick_d;

  always_comb begin
    // RUN implies per_q != 0, so per_q - 1 never underflows here.
    wrap    = (state_q == RUN) && (cnt_q == per_q - ONE);
    // Any period boundary: entering RUN, natural wrap or a sync restart.
    restart = (state_q == IDLE) || wrap || sync;
    apply   = pend_q && restart;
    per_d   = apply ? pper_q : per_q;
    hi_d    = apply ? phi_q  : hi_q;

    state_d = IDLE;
    cnt_d   = '0;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    // A zero period keeps the channel idle whatever en says.
    if (en && (per_d != '0)) begin
      state_d = RUN;
      cnt_d   = restart ? '0 : cnt_q + ONE;
      // Use the post-apply high-time so a new period starts cleanly.
      clk_d   = (cnt_d < hi_d);
      tick_d  = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= CNT_W'(DEF_PERIOD);
      hi_q    <= CNT_W'(DEF_HIGH);
      pper_q  <= '0;
      phi_q   <= '0;
      pend_q  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      clk_out <= clk_d;
      tick    <= tick_d;
      // A load on an apply edge is kept for the next boundary.
      pend_q  <= cfg_load | (pend_q & ~apply);
      if (cfg_load) begin
        pper_q <= cfg_period;
        phi_q  <= cfg_high;
      end
    end
  end

  assign cfg_pending = pend_q;
endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH independent programmable divided clocks from one system clock.
// Optional macro CLK_GEN_MULTI_PHASE_SYNC_EN adds input 'sync' that
// restarts every running channel on the same edge.
// Ports:
//   clk, rst    : system clock, async active-high reset
//   en          : per-channel run enable
//   cfg_period  : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   cfg_high    : per-channel high-time, same packing
//   cfg_load    : per-channel capture strobe
//   cfg_pending : per-channel captured-not-applied flag
//   clk_out     : per-channel divided clock
//   tick        : per-channel period-start pulse
module clk_gen_multi #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = int'(clk_gen_pkg::DEF_PERIOD),
  parameter int DEF_HIGH   = int'(clk_gen_pkg::DEF_HIGH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLK_GEN_MULTI_PHASE_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  input  logic [NUM_CH-1:0]       cfg_load,
  output logic [NUM_CH-1:0]       cfg_pending,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);
  logic sync_i;
`ifdef CLK_GEN_MULTI_PHASE_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_chan #(
      .CNT_W     (CNT_W),
      .DEF_PERIOD(DEF_PERIOD),
      .DEF_HIGH  (DEF_HIGH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[g]),
      .sync       (sync_i),
      .cfg_period (cfg_period[g*CNT_W +: CNT_W]),
      .cfg_high   (cfg_high[g*CNT_W +: CNT_W]),
      .cfg_load   (cfg_load[g]),
      .cfg_pending(cfg_pending[g]),
      .clk_out    (clk_out[g]),
      .tick       (tick[g])
    );
  end
endmodule

// File: tb/tb_clk_gen_multi.sv
module tb_clk_gen_multi;
  localparam int NC = 2;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync = 1'b0;
  logic [NC-1:0]    en = '0;
  logic [NC*CW-1:0] cfg_period = '0;
  logic [NC*CW-1:0] cfg_high = '0;
  logic [NC-1:0]    cfg_load = '0;
  logic [NC-1:0]    cfg_pending, clk_out, tick;

  int nvec = 0;
  int nerr = 0;

  clk_gen_multi #(.NUM_CH(NC), .CNT_W(CW), .DEF_PERIOD(4), .DEF_HIGH(2)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CLK_GEN_MULTI_PHASE_SYNC_EN
    .sync       (sync),
`endif
    .en         (en),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_load   (cfg_load),
    .cfg_pending(cfg_pending),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the current period per channel.
  int m_run[NC], m_pos[NC], m_per[NC], m_hi[NC];
  int m_pend[NC], m_pp[NC], m_ph[NC];
  logic [NC-1:0] m_clk, m_tick, m_pnd;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_per[i] = 4; m_hi[i] = 2;
      m_pend[i] = 0; m_pp[i] = 0; m_ph[i] = 0;
    end
    m_clk = '0; m_tick = '0; m_pnd = '0;
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < NC; i++) begin
      bit at_end, boundary;
      at_end   = (m_run[i] != 0) && (m_pos[i] == m_per[i] - 1);
      boundary = (m_run[i] == 0) || at_end || (sync == 1'b1);
      if (m_pend[i] != 0 && boundary) begin
        m_per[i] = m_pp[i]; m_hi[i] = m_ph[i]; m_pend[i] = 0;
      end
      if (cfg_load[i]) begin
        m_pp[i] = int'(cfg_period[i*CW +: CW]);
        m_ph[i] = int'(cfg_high[i*CW +: CW]);
        m_pend[i] = 1;
      end
      if (en[i] && m_per[i] > 0) begin
        m_pos[i] = boundary ? 0 : m_pos[i] + 1;
        m_run[i] = 1;
      end else begin
        m_pos[i] = 0;
        m_run[i] = 0;
      end
      m_clk[i]  = (m_run[i] != 0) && (m_pos[i] < m_hi[i]);
      m_tick[i] = (m_run[i] != 0) && (m_pos[i] == 0);
      m_pnd[i]  = (m_pend[i] != 0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(string nm, logic [NC-1:0] ec, logic [NC-1:0] et, logic [NC-1:0] ep);
    nvec++;
    if (clk_out !== ec || tick !== et || cfg_pending !== ep) begin
      nerr++;
      $display("FAIL %s: got clk_out=%b tick=%b pend=%b, expected %b %b %b",
               nm, clk_out, tick, cfg_pending, ec, et, ep);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, m_clk, m_tick, m_pnd);
  endtask

  task automatic set_cfg(int ch, int p, int h);
    cfg_period[ch*CW +: CW] = CW'(p);
    cfg_high[ch*CW +: CW]   = CW'(h);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; en = '0; cfg_load = '0; sync = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NC-1:0] en, ld;
    int            p, h;
    logic [NC-1:0] eclk, etick, epnd;
  } row_t;
  row_t tbl[20];

  initial begin
    int ticks;
    // ch0 at defaults, reconfigured to 10/3 mid-period, then stopped,
    // reloaded to 5/0 while idle and restarted.
    tbl[0]  = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b01, 2'b00};
    tbl[1]  = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b00, 2'b00};
    tbl[2]  = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b01, 2'b00};
    tbl[5]  = '{2'b01, 2'b01, 10, 3, 2'b01, 2'b00, 2'b01};
    tbl[6]  = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b01};
    tbl[7]  = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b01};
    tbl[8]  = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b01, 2'b00};
    tbl[9]  = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b00, 2'b00};
    tbl[10] = '{2'b01, 2'b00,  0, 0, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{2'b00, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{2'b00, 2'b01,  5, 0, 2'b00, 2'b00, 2'b01};
    tbl[14] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b01, 2'b00};
    tbl[15] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[16] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[17] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[18] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b00, 2'b00};
    tbl[19] = '{2'b01, 2'b00,  0, 0, 2'b00, 2'b01, 2'b00};

    model_reset();
    #12;
    chk("reset_state", 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[r]) begin
      en = tbl[r].en;
      cfg_load = tbl[r].ld;
      if (tbl[r].ld != '0) begin
        set_cfg(0, tbl[r].p, tbl[r].h);
        set_cfg(1, tbl[r].p, tbl[r].h);
      end
      step();
      chk($sformatf("table_row%0d", r), tbl[r].eclk, tbl[r].etick, tbl[r].epnd);
      chk_model($sformatf("table_model%0d", r));
    end
    cfg_load = '0;

    // high-time above period: clock held high, tick every 5 cycles.
    set_cfg(0, 5, 7); cfg_load = 2'b01;
    step(); cfg_load = '0;
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_model("high_ge_period");
      if (c >= 4 && clk_out[0] !== 1'b1) begin
        nvec++; nerr++;
        $display("FAIL high_ge_period_const: got clk_out=%b, expected 1", clk_out[0]);
      end
      if (c >= 4) ticks += int'(tick[0]);
    end
    nvec++;
    if (ticks != 1) begin
      nerr++;
      $display("FAIL high_ge_period_ticks: got %0d ticks, expected 1", ticks);
    end

    // en dropped at cnt=1 of a 4/2 period, then async reset mid-high.
    do_reset();
    en = 2'b01; step(); step();
    chk("drop_pre", 2'b01, 2'b00, 2'b00);
    en = 2'b00; step();
    chk("drop_at_cnt1", 2'b00, 2'b00, 2'b00);
    en = 2'b01; step();
    chk("restart_high", 2'b01, 2'b01, 2'b00);
    #2; rst = 1'b1; #1;
    chk("async_reset", 2'b00, 2'b00, 2'b00);
    model_reset();
    @(negedge clk); rst = 1'b0; en = 2'b00;

    // period 1 / high 1: constant high with a tick every cycle.
    set_cfg(0, 1, 1); cfg_load = 2'b01; step(); cfg_load = '0;
    en = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("period1_high1", 2'b01, 2'b01, 2'b00);
    end

    // period 0 with en=1: channel stays idle.
    set_cfg(0, 0, 0); cfg_load = 2'b01; step(); cfg_load = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("period0", 2'b00, 2'b00, 2'b00);
    end

`ifdef CLK_GEN_MULTI_PHASE_SYNC_EN
    do_reset();
    set_cfg(1, 6, 3); cfg_load = 2'b10; step(); cfg_load = '0;
    step();
    en = 2'b01; step(); step();
    en = 2'b11; step(); step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    chk("sync_align", 2'b11, 2'b11, 2'b00);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk_model("sync_follow");
    end
    chk("sync_realign12", 2'b11, 2'b11, 2'b00);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NC; i++) begin
        en[i] = ($urandom_range(0, 15) != 0);
        cfg_load[i] = ($urandom_range(0, 9) == 0);
        if (cfg_load[i]) set_cfg(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
      end
`ifdef CLK_GEN_MULTI_PHASE_SYNC_EN
      sync = ($urandom_range(0, 19) == 0);
`endif
      step();
      chk_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
